// File: rtl/mii_frame_gen_pkg.sv
// Shared definitions for the MII/GMII test-frame generator: FSM state
// encoding, framing byte constants, payload length limits and CRC-32 constants.
package mii_frame_gen_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        SFD,
        HEADER,
        PAYLOAD,
        FCS,
        IFG
    } state_t;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;

    localparam logic [10:0] MIN_PAYLOAD   = 11'd46;
    localparam logic [10:0] MAX_PAYLOAD   = 11'd1500;

    // Frame byte positions (index 0 is the first preamble byte)
    localparam logic [10:0] PREAMBLE_LEN  = 11'd7;
    localparam logic [10:0] HDR_START     = 11'd8;
    localparam logic [10:0] PAY_START     = 11'd22;
    // Offset from payload length to the index of the last FCS byte
    localparam logic [10:0] LAST_OFFSET   = 11'd25;

    localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    // Raw register value after running the CRC over data plus its own FCS
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

    // Limit a requested payload length to the legal Ethernet range
    function automatic logic [10:0] clamp_len(input logic [10:0] len);
        if (len < MIN_PAYLOAD)
            return MIN_PAYLOAD;
        else if (len > MAX_PAYLOAD)
            return MAX_PAYLOAD;
        else
            return len;
    endfunction

endpackage

// File: rtl/mii_frame_gen_crc32_byte.sv
// Combinational reflected CRC-32 update for one data byte (LSB first).
// The running CRC register lives in the parent module.
module crc32_byte
    import mii_frame_gen_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    logic [31:0] c;

    // Eight bit-serial steps of the reflected polynomial division
    always_comb begin
        c = crc_in ^ {24'h000000, data};
        for (int b = 0; b < 8; b++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/mii_frame_gen.sv
// Ethernet test-frame generator driving an MII (DW=4) or GMII-style (DW=8)
// receive interface: preamble, SFD, fixed header, counting payload, CRC-32
// FCS, then an idle inter-frame gap.
// Optional feature: define MII_FRAME_GEN_ERR_INJ_EN to add err_en/err_byte
// ports that raise phy_rx_er for every cycle of one chosen frame byte.
module mii_frame_gen
    import mii_frame_gen_pkg::*;
#(
    parameter int          DW        = 4,
    parameter logic [47:0] DST_MAC   = 48'h02_00_00_00_00_01,
    parameter logic [47:0] SRC_MAC   = 48'h02_00_00_00_00_02,
    parameter logic [15:0] ETHERTYPE = 16'h0800,
    parameter int          IFG_BYTES = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [10:0]   payload_len,
    input  logic [7:0]    seed,
`ifdef MII_FRAME_GEN_ERR_INJ_EN
    input  logic          err_en,
    input  logic [10:0]   err_byte,
`endif
    output logic          busy,
    output logic          done,
    output logic [15:0]   frames_sent,
    output logic [DW-1:0] phy_rxd,
    output logic          phy_rx_dv,
    output logic          phy_rx_er
);

    localparam int           IFG_CYC  = IFG_BYTES * (8 / DW);
    localparam logic [15:0]  IFG_LAST = 16'(IFG_CYC - 1);
    localparam logic [111:0] HDR      = {DST_MAC, SRC_MAC, ETHERTYPE};

    state_t      state, n_state;
    logic [10:0] idx, n_idx;
    logic        phase, n_phase;
    logic [15:0] ifg_cnt, n_ifg;
    logic [10:0] plen_r;
    logic [7:0]  seed_r;
    logic [31:0] crc_r, crc_nx;
    logic [7:0]  nbyte;
    logic        n_dv, n_done, n_er, crc_en;
    logic [DW-1:0] n_rxd;

`ifdef MII_FRAME_GEN_ERR_INJ_EN
    logic        err_en_r;
    logic [10:0] err_byte_r;
`endif

    // Which section of the frame a byte index falls into
    function automatic state_t region(input logic [10:0] i, input logic [10:0] plen);
        if (i < PREAMBLE_LEN)
            return PREAMBLE;
        else if (i == PREAMBLE_LEN)
            return SFD;
        else if (i < PAY_START)
            return HEADER;
        else if (i < PAY_START + plen)
            return PAYLOAD;
        else
            return FCS;
    endfunction

    // Byte value at frame index i; FCS bytes are the complemented CRC, LSB byte first
    function automatic logic [7:0] frame_byte(input state_t st, input logic [10:0] i,
                                              input logic [10:0] plen, input logic [7:0] sd,
                                              input logic [31:0] crc);
        logic [3:0] hj;
        logic [1:0] fj;
        hj = 4'(i - HDR_START);
        fj = 2'(i - PAY_START - plen);
        case (st)
            PREAMBLE: return PREAMBLE_BYTE;
            SFD:      return SFD_BYTE;
            HEADER:   return 8'(HDR >> {(4'd13 - hj), 3'b000});
            PAYLOAD:  return sd + 8'(i - PAY_START);
            FCS:      return 8'(~crc >> {fj, 3'b000});
            default:  return 8'h00;
        endcase
    endfunction

    crc32_byte u_crc (
        .crc_in  (crc_r),
        .data    (nbyte),
        .crc_out (crc_nx)
    );

    // Next frame position: advance nibble/byte, step through sections, count the gap
    always_comb begin
        n_state = state;
        n_idx   = idx;
        n_phase = phase;
        n_ifg   = ifg_cnt;
        unique case (state)
            IDLE: begin
                if (start) begin
                    n_state = PREAMBLE;
                    n_idx   = 11'd0;
                    n_phase = 1'b0;
                end
            end
            IFG: begin
                if (ifg_cnt == IFG_LAST)
                    n_state = IDLE;
                else
                    n_ifg = ifg_cnt + 16'd1;
            end
            default: begin
                if (DW == 4 && !phase) begin
                    n_phase = 1'b1;
                end else begin
                    n_phase = 1'b0;
                    if (idx == plen_r + LAST_OFFSET) begin
                        n_state = IFG;
                        n_ifg   = 16'd0;
                    end else begin
                        n_idx   = idx + 11'd1;
                        n_state = region(idx + 11'd1, plen_r);
                    end
                end
            end
        endcase
    end

    // Output values for the next position; CRC absorbs each new header/payload byte
    always_comb begin
        nbyte  = frame_byte(n_state, n_idx, plen_r, seed_r, crc_r);
        n_dv   = (n_state != IDLE) && (n_state != IFG);
        n_rxd  = n_dv ? DW'(nbyte >> {n_phase, 2'b00}) : '0;
        n_done = (n_state == IFG) && (n_ifg == IFG_LAST);
        crc_en = ((n_state == HEADER) || (n_state == PAYLOAD)) && !n_phase;
`ifdef MII_FRAME_GEN_ERR_INJ_EN
        if (state == IDLE)
            n_er = n_dv && err_en && (n_idx == err_byte);
        else
            n_er = n_dv && err_en_r && (n_idx == err_byte_r);
`else
        n_er   = 1'b0;
`endif
    end

    // Frame FSM with registered PHY outputs; datapath registers are not reset
    always_ff @(posedge clk) begin
        idx     <= n_idx;
        phase   <= n_phase;
        ifg_cnt <= n_ifg;
        if (state == IDLE && start) begin
            plen_r <= clamp_len(payload_len);
            seed_r <= seed;
            crc_r  <= CRC32_INIT;
`ifdef MII_FRAME_GEN_ERR_INJ_EN
            err_en_r   <= err_en;
            err_byte_r <= err_byte;
`endif
        end else if (crc_en) begin
            crc_r <= crc_nx;
        end

        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            frames_sent <= 16'd0;
            phy_rxd     <= '0;
            phy_rx_dv   <= 1'b0;
            phy_rx_er   <= 1'b0;
        end else begin
            state     <= n_state;
            busy      <= (n_state != IDLE);
            done      <= n_done;
            phy_rxd   <= n_rxd;
            phy_rx_dv <= n_dv;
            phy_rx_er <= n_er;
            if (n_done)
                frames_sent <= frames_sent + 16'd1;
        end
    end

endmodule
